// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, pad, optional FCS, IFG.
// Define GMII_TX_FCS_EN to append the Ethernet CRC-32 FCS.
module gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk125_i,
  input  logic        reset_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic [7:0]  Txd_o,
  output logic        Tx_en_o,
  output logic        Tx_er_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
`ifdef GMII_TX_FCS_EN
    FCS,
`endif
    IFG,
    DROP
  } state_t;

`ifdef GMII_TX_FCS_EN
  localparam state_t POST = FCS;
`else
  localparam state_t POST = IFG;
`endif

  state_t state;
  state_t state_nxt;

  logic [7:0]  cnt;
  logic [10:0] len;
  logic [10:0] len_inc;
  logic        xfer;
  logic        short_frame;
  logic        frame_done;
  logic [7:0]  txd_nxt;
  logic        en_nxt;
  logic        er_nxt;

  assign s_ready_o   = (state == DATA) || (state == DROP);
  assign busy_o      = (state != IDLE);
  assign xfer        = s_valid_i && s_ready_o;
  assign len_inc     = (&len) ? len : len + 11'd1;
  assign short_frame = len_inc < 11'(MIN_FRAME);
  assign frame_done  = (state_nxt == IFG) &&
                       (state != IFG) && (state != DROP);

`ifdef GMII_TX_FCS_EN
  logic [31:0] crc;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk125_i) begin
    if (reset_i || state == IDLE)
      crc <= 32'hFFFF_FFFF;
    else if (state == DATA && s_valid_i)
      crc <= crc_byte(crc, s_data_i);
    else if (state == PAD)
      crc <= crc_byte(crc, 8'h00);
  end

  // FCS goes out least-significant byte first
  always_comb begin
    fcs_byte = 8'h00;
    unique case (cnt[1:0])
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end
`endif

  always_ff @(posedge clk125_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (s_valid_i) state_nxt = PRE;
      PRE:  if (cnt == 8'd6) state_nxt = SFD;
      SFD:  state_nxt = DATA;
      DATA: begin
        if (!s_valid_i)
          state_nxt = DROP;
        else if (s_last_i)
          state_nxt = short_frame ? PAD : POST;
      end
      PAD:  if (!short_frame) state_nxt = POST;
`ifdef GMII_TX_FCS_EN
      FCS:  if (cnt == 8'd3) state_nxt = IFG;
`endif
      IFG:  if (cnt == 8'(IFG_BYTES - 1)) state_nxt = IDLE;
      DROP: if (xfer && s_last_i) state_nxt = IFG;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txd_nxt = 8'h00;
    en_nxt  = 1'b0;
    er_nxt  = 1'b0;
    unique case (state)
      PRE: begin
        txd_nxt = 8'h55;
        en_nxt  = 1'b1;
      end
      SFD: begin
        txd_nxt = 8'hD5;
        en_nxt  = 1'b1;
      end
      DATA: begin
        en_nxt = 1'b1;
        if (s_valid_i)
          txd_nxt = s_data_i;
        else
          er_nxt = 1'b1;
      end
      PAD: en_nxt = 1'b1;
`ifdef GMII_TX_FCS_EN
      FCS: begin
        txd_nxt = fcs_byte;
        en_nxt  = 1'b1;
      end
`endif
      default: en_nxt = 1'b0;
    endcase
  end

  // cnt restarts at zero on every state change
  always_ff @(posedge clk125_i) begin
    if (reset_i) begin
      cnt         <= 8'd0;
      len         <= 11'd0;
      Txd_o       <= 8'h00;
      Tx_en_o     <= 1'b0;
      Tx_er_o     <= 1'b0;
      frame_cnt_o <= 16'h0000;
    end else begin
      cnt     <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      Txd_o   <= txd_nxt;
      Tx_en_o <= en_nxt;
      Tx_er_o <= er_nxt;
      if (state == IDLE)
        len <= 11'd0;
      else if ((state == DATA && s_valid_i) || state == PAD)
        len <= len_inc;
      if (frame_done)
        frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: framing, pad, FCS, IFG,
// underrun, mid-frame reset and frame counter wrap.
module tb_gmii_tx_framer;

`ifdef GMII_TX_FCS_EN
  localparam int FL = 4;
`else
  localparam int FL = 0;
`endif

  logic        clk125_i = 1'b0;
  logic        reset_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic [7:0]  Txd_o;
  logic        Tx_en_o;
  logic        Tx_er_o;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  gmii_tx_framer dut (
    .clk125_i   (clk125_i),
    .reset_i    (reset_i),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .Txd_o      (Txd_o),
    .Tx_en_o    (Tx_en_o),
    .Tx_er_o    (Tx_er_o),
    .busy_o     (busy_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #4 clk125_i = ~clk125_i;

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [7:0] cur[$];
  logic [7:0] frm[$];
  int runs[$];
  int gaps[$];
  int hi_cnt = 0;
  int low_cnt = 0;
  int er_cnt = 0;
  int xfer_cnt = 0;
  int rdy_cnt = 0;
  logic en_q = 1'b0;
  logic er_en = 1'b0;
  logic [7:0] er_d = 8'h00;

  always @(negedge clk125_i) begin
    if (Tx_en_o) begin
      if (!en_q) begin
        gaps.push_back(low_cnt);
        cur.delete();
        hi_cnt = 0;
      end
      cur.push_back(Txd_o);
      hi_cnt++;
    end else begin
      if (en_q) begin
        runs.push_back(hi_cnt);
        frm = cur;
        low_cnt = 0;
      end
      low_cnt++;
    end
    if (Tx_er_o) begin
      er_cnt++;
      er_en = Tx_en_o;
      er_d  = Txd_o;
    end
    if (s_valid_i && s_ready_o) xfer_cnt++;
    if (s_ready_o) rdy_cnt++;
    en_q = Tx_en_o;
  end

  task automatic clr();
    runs.delete();
    gaps.delete();
    er_cnt   = 0;
    xfer_cnt = 0;
    rdy_cnt  = 0;
  endtask

  // gap_at: number of bytes sent before a one-cycle valid drop (-1 = none)
  task automatic send(input int n, input int gap_at);
    int  i = 0;
    int  t = 0;
    bit  gapped = 1'b0;
    while (i < n && t < 3000) begin
      @(posedge clk125_i);
      #1;
      t++;
      if (i == gap_at && !gapped) begin
        s_valid_i = 1'b0;
        gapped    = 1'b1;
      end else begin
        s_valid_i = 1'b1;
        s_data_i  = 8'(i + 1);
        s_last_i  = (i == n - 1);
      end
      if (s_valid_i && s_ready_o) i++;
    end
    check("send_to", 32'(i), 32'(n));
  endtask

  task automatic finish_frame();
    @(posedge clk125_i);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk125_i);
      #1;
      if (!busy_o) break;
    end
    check("idle_to", 32'(busy_o), 32'd0);
  endtask

  task automatic chk_frame(input int n);
    logic [7:0]  e[$];
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    tot = (n < 60) ? 60 : n;
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? 8'(i + 1) : 8'h00;
      e.push_back(b);
      c = crc_upd(c, b);
    end
`ifdef GMII_TX_FCS_EN
    c = ~c;
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
`endif
    check("frm_len", 32'(frm.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < frm.size())
        check($sformatf("byte%0d", i), 32'(frm[i]), 32'(e[i]));
`ifdef GMII_TX_FCS_EN
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < frm.size(); i++) c = crc_upd(c, frm[i]);
    check("residue", c, 32'hDEBB20E3);
`endif
  endtask

  initial begin
    int pcnt;
    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    repeat (3) @(posedge clk125_i);
    @(negedge clk125_i);
    #1;
    check("rst_en",    32'(Tx_en_o), 32'd0);
    check("rst_er",    32'(Tx_er_o), 32'd0);
    check("rst_txd",   32'(Txd_o), 32'd0);
    check("rst_ready", 32'(s_ready_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_cnt",   32'(frame_cnt_o), 32'd0);
    reset_i = 1'b0;

    // short frame: preamble, payload, pad, FCS
    clr();
    send(10, -1);
    finish_frame();
    check("t1_runs", 32'(runs.size()), 32'd1);
    check("t1_hi", 32'(runs[0]), 32'(68 + FL));
    check("t1_er", 32'(er_cnt), 32'd0);
    chk_frame(10);
    check("t1_cnt", 32'(frame_cnt_o), 32'd1);

    // long frame: no pad, IFG after
    clr();
    send(100, -1);
    finish_frame();
    check("t2_hi", 32'(runs[0]), 32'(108 + FL));
    check("t2_low", 32'(low_cnt), 32'd12);
    check("t2_xfer", 32'(xfer_cnt), 32'd100);
    check("t2_rdy", 32'(rdy_cnt), 32'd100);
    chk_frame(100);
    check("t2_cnt", 32'(frame_cnt_o), 32'd2);

    // back-to-back frames with valid held high
    clr();
    send(64, -1);
    send(64, -1);
    finish_frame();
    check("t3_runs", 32'(runs.size()), 32'd2);
    check("t3_hi0", 32'(runs[0]), 32'(72 + FL));
    check("t3_hi1", 32'(runs[1]), 32'(72 + FL));
    check("t3_gap", 32'(gaps[1]), 32'd13);
    chk_frame(64);
    check("t3_cnt", 32'(frame_cnt_o), 32'd4);

    // underrun after byte 20 of 30
    clr();
    send(30, 20);
    finish_frame();
    check("t4_er", 32'(er_cnt), 32'd1);
    check("t4_er_en", 32'(er_en), 32'd1);
    check("t4_er_d", 32'(er_d), 32'd0);
    check("t4_hi", 32'(runs[0]), 32'd29);
    check("t4_xfer", 32'(xfer_cnt), 32'd30);
    check("t4_cnt", 32'(frame_cnt_o), 32'd4);

    // reset during 5th preamble byte
    clr();
    @(posedge clk125_i);
    #1;
    s_valid_i = 1'b1;
    s_data_i  = 8'h01;
    pcnt = 0;
    for (int k = 0; k < 50 && pcnt < 5; k++) begin
      @(negedge clk125_i);
      #1;
      if (Tx_en_o && Txd_o == 8'h55) pcnt++;
    end
    check("t5_pre", 32'(pcnt), 32'd5);
    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    @(negedge clk125_i);
    #1;
    check("t5_en",    32'(Tx_en_o), 32'd0);
    check("t5_er",    32'(Tx_er_o), 32'd0);
    check("t5_txd",   32'(Txd_o), 32'd0);
    check("t5_ready", 32'(s_ready_o), 32'd0);
    check("t5_busy",  32'(busy_o), 32'd0);
    check("t5_cnt",   32'(frame_cnt_o), 32'd0);
    reset_i = 1'b0;
    clr();
    send(10, -1);
    finish_frame();
    check("t5_hi", 32'(runs[0]), 32'(68 + FL));
    check("t5_er_n", 32'(er_cnt), 32'd0);
    chk_frame(10);
    check("t5_cnt2", 32'(frame_cnt_o), 32'd1);

    // counter wrap from 0xFFFF
    @(negedge clk125_i);
    force dut.frame_cnt_o = 16'hFFFF;
    @(negedge clk125_i);
    release dut.frame_cnt_o;
    #1;
    check("t6_pre", 32'(frame_cnt_o), 32'hFFFF);
    clr();
    send(10, -1);
    finish_frame();
    check("t6_wrap", 32'(frame_cnt_o), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
